// File: rtl/machine_mode_types_1_12_pkg.sv
// machine_mode_types_1_12_pkg: shared types and constants for the v1.12 CSR access path.
package machine_mode_types_1_12_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} csr_ctrl_state_t;
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;
endpackage

// File: rtl/priv_1_12_csr_alu.sv
// priv_1_12_csr_alu: Zicsr read-modify-write value and write-intent computation.
module priv_1_12_csr_alu
  import machine_mode_types_1_12_pkg::*;
(
  input  logic [2:0] op_i,
  input  word_t      old_i,
  input  word_t      operand_i,
  input  logic       rs1_zero_i,
  output word_t      new_o,
  output logic       write_o
);
  logic is_w, is_s, is_c;
  always_comb begin
    is_w = op_i == CSR_RW || op_i == CSR_RWI;
    is_s = op_i == CSR_RS || op_i == CSR_RSI;
    is_c = op_i == CSR_RC || op_i == CSR_RCI;
    new_o = is_w ? operand_i : is_s ? (old_i | operand_i) : (old_i & ~operand_i);
    write_o = is_w || ((is_s || is_c) && !rs1_zero_i);
  end
endmodule

// File: rtl/priv_1_12_csr_ctrl.sv
// priv_1_12_csr_ctrl: atomic Zicsr read-modify-write initiator toward the CSR file.
// Define PRIV_CSR_ACCESS_CHECK_EN to add privilege and read-only access faults.
module priv_1_12_csr_ctrl
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_uimm,
  input  logic            req_rs1_zero,
  input  logic [1:0]      req_priv,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  input  logic            retire_in,
  output logic [11:0]     csr_addr,
  output logic [1:0]      curr_priv,
  output logic            csr_mod,
  output logic [XLEN-1:0] new_csr_val,
  output logic            inst_ret,
  input  logic [XLEN-1:0] old_csr_val,
  input  logic            invalid_csr
);
  csr_ctrl_state_t state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0] priv_q, priv_d;
  logic [2:0] op_q, op_d;
  logic [XLEN-1:0] operand_q, operand_d, rdata_q, rdata_d, new_q, new_d, alu_new;
  logic rz_q, rz_d, illegal_q, illegal_d, ret_q, ret_d, pend_q, pend_d;
  logic alu_write, priv_fault, illegal, pulse;

  priv_1_12_csr_alu u_alu (
    .op_i      (op_q),
    .old_i     (old_csr_val),
    .operand_i (operand_q),
    .rs1_zero_i(rz_q),
    .new_o     (alu_new),
    .write_o   (alu_write)
  );

`ifdef PRIV_CSR_ACCESS_CHECK_EN
  assign priv_fault = (priv_q < addr_q[9:8]) || (addr_q[11:10] == CSR_RO_FIELD && alu_write);
`else
  assign priv_fault = 1'b0;
`endif
  assign illegal = invalid_csr || op_q == 3'b000 || op_q == 3'b100 || priv_fault;

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    priv_d = priv_q;
    op_d = op_q;
    operand_d = operand_q;
    rz_d = rz_q;
    rdata_d = rdata_q;
    illegal_d = illegal_q;
    new_d = new_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d = req_addr;
        priv_d = req_priv;
        op_d = req_op;
        operand_d = req_op[2] ? {{(XLEN-5){1'b0}}, req_uimm} : req_rs1_val;
        rz_d = req_rs1_zero;
        state_d = READ;
      end
      READ: begin
        rdata_d = old_csr_val;
        illegal_d = illegal;
        new_d = alu_new;
        state_d = (illegal || !alu_write) ? RESP : WRITE;
      end
      WRITE: state_d = RESP;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    // A CSR completion colliding with a pipeline retire is deferred one cycle.
    pulse = state_q == RESP && resp_ready && !illegal_q;
    ret_d = retire_in || pend_q || pulse;
    pend_d = retire_in && (pend_q || pulse);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q <= '0;
      priv_q <= 2'b11;
      op_q <= '0;
      operand_q <= '0;
      rz_q <= 1'b0;
      rdata_q <= '0;
      illegal_q <= 1'b0;
      new_q <= '0;
      ret_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      priv_q <= priv_d;
      op_q <= op_d;
      operand_q <= operand_d;
      rz_q <= rz_d;
      rdata_q <= rdata_d;
      illegal_q <= illegal_d;
      new_q <= new_d;
      ret_q <= ret_d;
      pend_q <= pend_d;
    end
  end

  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign csr_mod = state_q == WRITE;
  assign resp_rdata = rdata_q;
  assign resp_illegal = illegal_q;
  assign csr_addr = addr_q;
  assign curr_priv = priv_q;
  assign new_csr_val = new_q;
  assign inst_ret = ret_q;
endmodule
